conv3x3_row_engine: RTL and testbench
=====================================

# conv3x3_row_engine

Streaming 3×3 convolution engine for one output row. It takes one pixel column per handshake (three vertically adjacent rows, from the upstream line buffer) and keeps a 3-column sliding window. At every stride-aligned window position it produces one registered multiply-accumulate result against a locally stored 3×3 signed kernel. It sits between the line-buffer/shift logic and the activation/pooling stage of the NPU datapath, and generalises the earlier fixed-width stride controller with run-time stride, programmable weights and a full valid/ready input handshake.

## Interface
- BIT_DEPTH, 8, unsigned pixel width and signed weight width
- IMG_WIDTH, 28, columns per input row (≥3)
- ACC_WIDTH, 2*BIT_DEPTH+5, signed accumulator/output width (holds 9 full-scale products)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one row; sampled in IDLE only
- stride  in  2  1..3; 0 is treated as 1; latched on accepted start
- in_valid  in  1  column present on in_l1..in_l3
- in_ready  out  1  engine accepts column this cycle
- in_l1, in_l2, in_l3  in  BIT_DEPTH each  top/middle/bottom row pixel of incoming column
- w_load  in  1  write one kernel weight; honoured in IDLE only
- w_idx  in  4  weight index = row*3+col (col 0 = oldest column); 9..15 ignored
- w_data  in  BIT_DEPTH  signed weight value
- out_data  out  ACC_WIDTH  signed convolution result
- out_valid  out  1  one-cycle pulse, out_data valid
- busy  out  1  high in FILL/RUN/DONE
- done  out  1  one-cycle pulse at end of row

## Operation
- States: IDLE → (start) FILL → (3rd column accepted) RUN → (column IMG_WIDTH-1 accepted) DONE → IDLE.
- Accept = in_valid & in_ready; in_ready = 1 in FILL and RUN, 0 in IDLE and DONE.
- Column counter col_cnt: cleared on start, incremented on each accept, range 0..IMG_WIDTH-1.
- Window: 3×3 shift register; on accept, col0←col1, col1←col2, col2←{in_l1,in_l2,in_l3}.
- Emit condition on accept of column k: k≥2 and (k-2) mod stride == 0. Phase counter resets to 0 at k=2 and wraps at stride; no modulo hardware.
- Result = Σ pixel[r][c] (zero-extended, unsigned) × weight[r][c] (signed) over the window including the new column. Computed at full precision, then registered into out_data.
- Outputs per row: floor((IMG_WIDTH-3)/stride)+1. The trailing columns that do not complete a stride step are consumed without output.
- Weights persist across rows. w_load and start in the same IDLE cycle: the weight write occurs and the row starts with the new weight.
- start while busy ignored; w_load while busy ignored; in_valid in IDLE ignored (not accepted).
- Stride is held constant for the entire row regardless of the stride input after start.

## Timing
- Reset: state IDLE; out_data=0, out_valid=0, done=0, busy=0, in_ready=0; window, counters and weights cleared to 0.
- Reset mid-row aborts immediately: no done, no out_valid. After release the engine is in IDLE.
- Latency: out_valid asserts the cycle after the accepting edge of an emitting column; out_data is held until the next emission.
- done asserts the cycle after the last column is accepted (DONE state), coincident with the final out_valid when that column emits.
- busy rises the cycle after start is sampled and falls the cycle after DONE.
- Input gaps (in_valid=0) stall the window and counters with no side effects. There is no output backpressure, so the consumer must always accept out_valid.
- Minimum row time: 1 (start) + IMG_WIDTH accepts + 1 (DONE) cycles.

## Configuration
- CONV_RELU_EN defined: a negative result is clamped to 0 before registering into out_data; non-negative results pass unchanged.
- Undefined: out_data carries the raw signed sum, two's complement.

## Test plan
- IMG_WIDTH=5, stride=1, all pixels=1, all weights=1 → three out_valid pulses, each out_data=9; done one cycle after 5th accept, with 3rd output.
- Same setup, stride=2 → two outputs (columns 2 and 4), each 9; stride=3 → one output (column 2), 9; stride=0 behaves as stride 1.
- Pixels 255, weights −128 (0x80) → out_data = 9×255×(−128) = −293760 without CONV_RELU_EN; 0 with it.
- in_valid toggled every other cycle, stride=1 → same three values as scenario 1, each out_valid one cycle after its emitting accept, no extra pulses.
- rst asserted after 3rd accept → outputs and weights zero; no done; next start with reloaded weights reproduces scenario 1.
- start and w_load pulsed during RUN → ignored; results unchanged, weights unchanged, in_ready stays 1.

Source files
------------

// File: rtl/conv3x3_row_engine.sv
// Streaming 3x3 convolution over one output row: 3-column sliding window, run-time stride,
// programmable signed kernel. Optional ReLU clamp on the result when CONV_RELU_EN is defined.
module conv3x3_row_engine #(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned IMG_WIDTH = 28,
  parameter int unsigned ACC_WIDTH = 2 * BIT_DEPTH + 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           stride,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_DEPTH-1:0] in_l1,
  input  logic [BIT_DEPTH-1:0] in_l2,
  input  logic [BIT_DEPTH-1:0] in_l3,
  input  logic                 w_load,
  input  logic [3:0]           w_idx,
  input  logic [BIT_DEPTH-1:0] w_data,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CntW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
  localparam logic [CntW-1:0] LastCol = CntW'(IMG_WIDTH - 1);
  localparam logic [CntW-1:0] FillCol = CntW'(2);
  localparam int unsigned ExtW = ACC_WIDTH - BIT_DEPTH;

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      col_cnt_q, col_cnt_d;
  logic [1:0]           stride_q, stride_d;
  logic [1:0]           phase_q, phase_d;
  logic [BIT_DEPTH-1:0] win_q [3][3];  // [row][col], col 0 is the oldest column
  logic [BIT_DEPTH-1:0] win_d [3][3];
  logic [BIT_DEPTH-1:0] wgt_q [9];
  logic [BIT_DEPTH-1:0] wgt_d [9];
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;

  logic                        accept;
  logic                        emit;
  logic [1:0]                  phase_cur;
  logic [BIT_DEPTH-1:0]        col_new [3];
  logic [BIT_DEPTH-1:0]        tap [9];
  logic signed [ACC_WIDTH-1:0] prod [9];
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] result;

  assign in_ready = (state_q == StFill) || (state_q == StRun);
  assign accept   = in_valid && in_ready;

  assign col_new[0] = in_l1;
  assign col_new[1] = in_l2;
  assign col_new[2] = in_l3;

  // The window position at column 2 always emits; the phase then steps modulo stride.
  assign phase_cur = (col_cnt_q == FillCol) ? 2'd0 : phase_q;
  assign emit      = accept && (col_cnt_q >= FillCol) && (phase_cur == 2'd0);

  // Taps see the window as it will be after the shift, i.e. including the new column.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      tap[r*3]     = win_q[r][1];
      tap[r*3 + 1] = win_q[r][2];
      tap[r*3 + 2] = col_new[r];
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      prod[i] = $signed({{ExtW{1'b0}}, tap[i]}) *
                $signed({{ExtW{wgt_q[i][BIT_DEPTH-1]}}, wgt_q[i]});
      sum = sum + prod[i];
    end
  end

  always_comb begin
`ifdef CONV_RELU_EN
    result = sum[ACC_WIDTH-1] ? '0 : sum;
`else
    result = sum;
`endif
  end

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    stride_d    = stride_q;
    phase_d     = phase_q;
    win_d       = win_q;
    wgt_d       = wgt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    if ((state_q == StIdle) && w_load && (w_idx < 4'd9)) begin
      wgt_d[w_idx] = w_data;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFill;
          col_cnt_d = '0;
          phase_d   = 2'd0;
          stride_d  = (stride == 2'd0) ? 2'd1 : stride;
        end
      end
      StFill, StRun: begin
        if (accept) begin
          for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
            win_d[r][2] = col_new[r];
          end
          if (col_cnt_q >= FillCol) begin
            phase_d = (phase_cur == stride_q - 2'd1) ? 2'd0 : phase_cur + 2'd1;
          end
          if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
          end
          if (col_cnt_q == LastCol) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            col_cnt_d = col_cnt_q + CntW'(1);
            if (col_cnt_q == FillCol) begin
              state_d = StRun;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      col_cnt_q   <= '0;
      stride_q    <= 2'd1;
      phase_q     <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      for (int i = 0; i < 9; i++) begin
        wgt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      stride_q    <= stride_d;
      phase_q     <= phase_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      win_q       <= win_d;
      wgt_q       <= wgt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_conv3x3_row_engine.sv
// Directed bench for conv3x3_row_engine at IMG_WIDTH=5: vector table of rows plus
// hand-written reset-abort, busy-time disturbance and load-with-start sequences.
module tb_conv3x3_row_engine;

  localparam int W  = 5;
  localparam int BD = 8;
  localparam int AW = 2 * BD + 5;

`ifdef CONV_RELU_EN
  localparam int NegBig   = 0;
  localparam int NegSmall = 0;
`else
  localparam int NegBig   = -293760;
  localparam int NegSmall = -54;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    stride = 2'd1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BD-1:0] in_l1 = '0, in_l2 = '0, in_l3 = '0;
  logic          w_load = 1'b0;
  logic [3:0]    w_idx = '0;
  logic [BD-1:0] w_data = '0;
  logic [AW-1:0] out_data;
  logic          out_valid, busy, done;

  int checks = 0;
  int errors = 0;

  conv3x3_row_engine #(.BIT_DEPTH(BD), .IMG_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stride   (stride),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_l1    (in_l1),
    .in_l2    (in_l2),
    .in_l3    (in_l3),
    .w_load   (w_load),
    .w_idx    (w_idx),
    .w_data   (w_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int stride;
    bit gap;
    int wmode;  // 0: all wval, 1: w[i]=i+1, 2: oldest column only = 1
    int wval;
    int pmode;  // 0: all pval, 1: row r = r+1, 2: column k = k+1
    int pval;
    int n;
    int e0, e1, e2;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [BD-1:0] pixf(input int pmode, input int pval, input int k,
                                         input int r);
    case (pmode)
      0:       return BD'(pval);
      1:       return BD'(r + 1);
      default: return BD'(k + 1);
    endcase
  endfunction

  task automatic load_weights(input int wmode, input int wval);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      w_load = 1'b1;
      w_idx  = 4'(i);
      case (wmode)
        0:       w_data = BD'(wval);
        1:       w_data = BD'(i + 1);
        default: w_data = (i % 3 == 0) ? BD'(1) : BD'(0);
      endcase
    end
    @(negedge clk);
    w_load = 1'b0;
  endtask

  task automatic run_row(input string tag, input int s, input bit gap, input int pmode,
                         input int pval, input bit disturb, input bit wl_start, input int n_exp,
                         input int e0, input int e1, input int e2);
    int e[3];
    int k, cyc, nout, seff;
    bit v, emit_exp, last_exp;
    e[0] = e0; e[1] = e1; e[2] = e2;
    seff = (s == 0) ? 1 : s;
    @(negedge clk);
    check({tag, "_ready_idle"}, int'(in_ready), 0);
    start  = 1'b1;
    stride = 2'(s);
    if (wl_start) begin
      w_load = 1'b1; w_idx = 4'd0; w_data = BD'(2);
    end
    @(negedge clk);
    start  = 1'b0;
    w_load = 1'b0;
    check({tag, "_busy_rise"}, int'(busy), 1);
    k = 0; cyc = 0; nout = 0;
    while (k < W && cyc < 200) begin
      v        = !gap || (cyc % 2 == 0);
      in_valid = v;
      in_l1    = pixf(pmode, pval, k, 0);
      in_l2    = pixf(pmode, pval, k, 1);
      in_l3    = pixf(pmode, pval, k, 2);
      if (disturb && k == 3) begin
        start = 1'b1; w_load = 1'b1; w_idx = 4'd0; w_data = 8'hfb; stride = 2'd3;
      end
      @(negedge clk);
      start = 1'b0; w_load = 1'b0; stride = 2'(s);
      emit_exp = v && k >= 2 && ((k - 2) % seff == 0);
      last_exp = v && k == W - 1;
      check($sformatf("%s_valid_k%0d_c%0d", tag, k, cyc), int'(out_valid), int'(emit_exp));
      check($sformatf("%s_done_k%0d_c%0d", tag, k, cyc), int'(done), int'(last_exp));
      if (out_valid) begin
        if (nout < 3) check($sformatf("%s_data%0d", tag, nout), int'($signed(out_data)), e[nout]);
        nout++;
      end
      if (v) k++;
      if (k < W) check($sformatf("%s_ready_k%0d", tag, k), int'(in_ready), 1);
      else begin
        check({tag, "_busy_done"}, int'(busy), 1);
        check({tag, "_ready_done"}, int'(in_ready), 0);
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 200) check({tag, "_timeout"}, k, W);
    check({tag, "_count"}, nout, n_exp);
    @(negedge clk);
    check({tag, "_busy_fall"}, int'(busy), 0);
    check({tag, "_done_end"}, int'(done), 0);
    check({tag, "_valid_end"}, int'(out_valid), 0);
    if (n_exp > 0) check({tag, "_hold"}, int'($signed(out_data)), e[n_exp-1]);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{stride: 1, gap: 0, wmode: 0, wval: 1,    pmode: 0, pval: 1,   n: 3,
                e0: 9, e1: 9, e2: 9};
    vecs[1] = '{stride: 2, gap: 0, wmode: 0, wval: 1,    pmode: 0, pval: 1,   n: 2,
                e0: 9, e1: 9, e2: 0};
    vecs[2] = '{stride: 3, gap: 0, wmode: 0, wval: 1,    pmode: 0, pval: 1,   n: 1,
                e0: 9, e1: 0, e2: 0};
    vecs[3] = '{stride: 0, gap: 0, wmode: 0, wval: 1,    pmode: 0, pval: 1,   n: 3,
                e0: 9, e1: 9, e2: 9};
    vecs[4] = '{stride: 1, gap: 0, wmode: 0, wval: -128, pmode: 0, pval: 255, n: 3,
                e0: NegBig, e1: NegBig, e2: NegBig};
    vecs[5] = '{stride: 1, gap: 1, wmode: 0, wval: 1,    pmode: 0, pval: 1,   n: 3,
                e0: 9, e1: 9, e2: 9};
    vecs[6] = '{stride: 1, gap: 0, wmode: 1, wval: 0,    pmode: 1, pval: 0,   n: 3,
                e0: 108, e1: 108, e2: 108};
    vecs[7] = '{stride: 1, gap: 0, wmode: 2, wval: 0,    pmode: 2, pval: 0,   n: 3,
                e0: 3, e1: 6, e2: 9};
    vecs[8] = '{stride: 2, gap: 0, wmode: 2, wval: 0,    pmode: 2, pval: 0,   n: 2,
                e0: 3, e1: 9, e2: 0};
    vecs[9] = '{stride: 1, gap: 0, wmode: 0, wval: -2,   pmode: 0, pval: 3,   n: 3,
                e0: NegSmall, e1: NegSmall, e2: NegSmall};

    repeat (2) @(negedge clk);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      load_weights(vecs[i].wmode, vecs[i].wval);
      run_row($sformatf("v%0d", i), vecs[i].stride, vecs[i].gap, vecs[i].pmode, vecs[i].pval,
              1'b0, 1'b0, vecs[i].n, vecs[i].e0, vecs[i].e1, vecs[i].e2);
    end

    // Reset in the middle of a row
    load_weights(0, 1);
    @(negedge clk);
    start = 1'b1; stride = 2'd1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_l1 = 8'd1; in_l2 = 8'd1; in_l3 = 8'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("abort_pre_valid", int'(out_valid), 1);
    check("abort_pre_data", int'($signed(out_data)), 9);
    rst = 1'b1;
    #1;
    check("abort_out_data", int'(out_data), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_no_done%0d", c), int'(done), 0);
      check($sformatf("abort_idle%0d", c), int'(busy), 0);
    end
    run_row("zerow", 1, 1'b0, 0, 1, 1'b0, 1'b0, 3, 0, 0, 0);
    load_weights(0, 1);
    run_row("reload", 1, 1'b0, 0, 1, 1'b0, 1'b0, 3, 9, 9, 9);

    // start, w_load and stride changes while busy are ignored
    run_row("disturb", 1, 1'b0, 0, 1, 1'b1, 1'b0, 3, 9, 9, 9);
    run_row("persist", 1, 1'b0, 0, 1, 1'b0, 1'b0, 3, 9, 9, 9);

    // Weight write coinciding with start takes effect for that row and persists
    run_row("wlstart", 1, 1'b0, 0, 1, 1'b0, 1'b1, 3, 10, 10, 10);
    run_row("wlkeep", 2, 1'b0, 0, 1, 1'b0, 1'b0, 2, 10, 10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
